// File: rtl/if_stage_pkg.sv
// Shared pipeline definitions: word width, reset/bubble constants
// and the instruction-fetch state encoding.
package if_stage_pkg;

    localparam int WORD_W = 32;

    localparam logic [WORD_W-1:0] RESET_PC_DEF  = 32'h0000_0000;
    localparam logic [WORD_W-1:0] NOP_INSTR_DEF = 32'h0000_0000;
    localparam logic [WORD_W-1:0] PC_STEP       = 32'd4;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/if_id_register.sv
// IF/ID pipeline register: bubble beats hold, hold beats load.
// A bubble keeps the old PC+4; only instr and valid are overwritten.
module if_id_register
    import if_stage_pkg::*;
#(
    parameter logic [WORD_W-1:0] NOP_INSTR = NOP_INSTR_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              hold,
    input  logic              bubble,
    input  logic              load,
    input  logic [WORD_W-1:0] instr_in,
    input  logic [WORD_W-1:0] pc4_in,
    output logic [WORD_W-1:0] instr,
    output logic [WORD_W-1:0] pc_incr4,
    output logic              valid
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr    <= NOP_INSTR;
            pc_incr4 <= '0;
            valid    <= 1'b0;
        end else if (bubble) begin
            instr    <= NOP_INSTR;
            valid    <= 1'b0;
        end else if (!hold && load) begin
            instr    <= instr_in;
            pc_incr4 <= pc4_in;
            valid    <= 1'b1;
        end
    end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch: PC, imem req/ready handshake, skid buffer for
// load-use stalls and branch redirect (DRAIN waits out an in-flight fetch).
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [WORD_W-1:0] RESET_PC  = RESET_PC_DEF,
    parameter logic [WORD_W-1:0] NOP_INSTR = NOP_INSTR_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_ID,
    input  logic              branch_taken,
    input  logic [WORD_W-1:0] branch_target,
    output logic              imem_req,
    output logic [WORD_W-1:0] imem_addr,
    input  logic [WORD_W-1:0] imem_rdata,
    input  logic              imem_ready,
    output logic [WORD_W-1:0] instr_ID,
    output logic [WORD_W-1:0] pc_incr4_ID,
    output logic              valid_ID,
    output logic [WORD_W-1:0] pc_IF
);

    fetch_state_t      state, state_n;
    logic [WORD_W-1:0] pc, pc_n;
    logic [WORD_W-1:0] pend, pend_n;
    logic [WORD_W-1:0] skid_instr, skid_instr_n;
    logic [WORD_W-1:0] skid_pc4, skid_pc4_n;
    logic [WORD_W-1:0] pc4;
    logic [WORD_W-1:0] ld_instr, ld_pc4;
    logic              ld, hold, bubble;

    assign pc4       = pc + PC_STEP;
    assign pc_IF     = pc;
    assign imem_addr = pc;
    // Gate with rst so the request drops the instant reset is applied.
    assign imem_req  = !rst && (state != HOLD);

    assign ld_instr = (state == HOLD) ? skid_instr : imem_rdata;
    assign ld_pc4   = (state == HOLD) ? skid_pc4   : pc4;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= FETCH;
            pc         <= RESET_PC;
            pend       <= '0;
            skid_instr <= '0;
            skid_pc4   <= '0;
        end else begin
            state      <= state_n;
            pc         <= pc_n;
            pend       <= pend_n;
            skid_instr <= skid_instr_n;
            skid_pc4   <= skid_pc4_n;
        end
    end

    always_comb begin
        state_n      = state;
        pc_n         = pc;
        pend_n       = pend;
        skid_instr_n = skid_instr;
        skid_pc4_n   = skid_pc4;
        ld           = 1'b0;
        hold         = 1'b0;
        bubble       = 1'b0;
        unique case (state)
            FETCH: begin
                if (branch_taken) begin
                    bubble       = 1'b1;
                    skid_instr_n = '0;
                    skid_pc4_n   = '0;
                    if (imem_ready) begin
                        pc_n = branch_target;
                    end else begin
                        pend_n  = branch_target;
                        state_n = DRAIN;
                    end
                end else if (imem_ready) begin
                    pc_n = pc4;
                    if (stall_ID) begin
                        hold         = 1'b1;
                        skid_instr_n = imem_rdata;
                        skid_pc4_n   = pc4;
                        state_n      = HOLD;
                    end else begin
                        ld = 1'b1;
                    end
                end else if (stall_ID) begin
                    hold = 1'b1;
                end else begin
                    bubble = 1'b1;
                end
            end
            HOLD: begin
                if (branch_taken) begin
                    bubble       = 1'b1;
                    skid_instr_n = '0;
                    skid_pc4_n   = '0;
                    pc_n         = branch_target;
                    state_n      = FETCH;
                end else if (stall_ID) begin
                    hold = 1'b1;
                end else begin
                    ld      = 1'b1;
                    state_n = FETCH;
                end
            end
            DRAIN: begin
                bubble = 1'b1;
                if (branch_taken) begin
                    pend_n = branch_target;
                end
                // Youngest redirect wins if it lands with the response.
                if (imem_ready) begin
                    pc_n    = branch_taken ? branch_target : pend;
                    state_n = FETCH;
                end
            end
            default: begin
                state_n = FETCH;
            end
        endcase
    end

    if_id_register #(
        .NOP_INSTR(NOP_INSTR)
    ) u_if_id (
        .clk      (clk),
        .rst      (rst),
        .hold     (hold),
        .bubble   (bubble),
        .load     (ld),
        .instr_in (ld_instr),
        .pc4_in   (ld_pc4),
        .instr    (instr_ID),
        .pc_incr4 (pc_incr4_ID),
        .valid    (valid_ID)
    );

endmodule

// File: tb/tb_if_stage.sv
// Scoreboard bench for if_stage: stimulus pushes expected IF/ID and PC
// state per cycle, a negedge monitor pops and compares.
module tb_if_stage;

    logic        clk;
    logic        rst;
    logic        stall_ID;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ready;
    logic [31:0] instr_ID;
    logic [31:0] pc_incr4_ID;
    logic        valid_ID;
    logic [31:0] pc_IF;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc4;
        logic        valid;
        logic [31:0] pc;
        logic        req;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    if_stage dut (
        .clk           (clk),
        .rst           (rst),
        .stall_ID      (stall_ID),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_rdata    (imem_rdata),
        .imem_ready    (imem_ready),
        .instr_ID      (instr_ID),
        .pc_incr4_ID   (pc_incr4_ID),
        .valid_ID      (valid_ID),
        .pc_IF         (pc_IF)
    );

    // Memory image: word at address A is A + 0x100.
    assign imem_rdata = imem_addr + 32'h100;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %08h expected %08h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("instr_ID", instr_ID, e.instr);
            chk("valid_ID", {31'd0, valid_ID}, {31'd0, e.valid});
            if (e.valid)
                chk("pc_incr4_ID", pc_incr4_ID, e.pc4);
            chk("pc_IF", pc_IF, e.pc);
            chk("imem_addr", imem_addr, e.pc);
            chk("imem_req", {31'd0, imem_req}, {31'd0, e.req});
        end
    end

    task automatic step(input logic rdy, input logic stl, input logic br,
                        input logic [31:0] tgt, input logic [31:0] ei,
                        input logic [31:0] ep4, input logic ev,
                        input logic [31:0] epc, input logic ereq);
        exp_t e;
        imem_ready    = rdy;
        stall_ID      = stl;
        branch_taken  = br;
        branch_target = tgt;
        @(posedge clk);
        e.instr = ei;
        e.pc4   = ep4;
        e.valid = ev;
        e.pc    = epc;
        e.req   = ereq;
        q.push_back(e);
        #1;
    endtask

    initial begin
        rst           = 1'b1;
        stall_ID      = 1'b0;
        branch_taken  = 1'b0;
        branch_target = '0;
        imem_ready    = 1'b0;
        #2;
        chk("rst_instr", instr_ID, 32'h0);
        chk("rst_valid", {31'd0, valid_ID}, 32'h0);
        chk("rst_pc4", pc_incr4_ID, 32'h0);
        chk("rst_pc", pc_IF, 32'h0);
        chk("rst_req", {31'd0, imem_req}, 32'h0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;

        // straight-line fetch
        step(1, 0, 0, 0, 32'h100, 32'h4, 1, 32'h4, 1);
        step(1, 0, 0, 0, 32'h104, 32'h8, 1, 32'h8, 1);
        // load-use stall into skid, then release
        step(1, 1, 0, 0, 32'h104, 32'h8, 1, 32'hC, 0);
        step(1, 1, 0, 0, 32'h104, 32'h8, 1, 32'hC, 0);
        step(1, 0, 0, 0, 32'h108, 32'hC, 1, 32'hC, 1);
        step(1, 0, 0, 0, 32'h10C, 32'h10, 1, 32'h10, 1);
        // branch with single-cycle memory
        step(1, 0, 1, 32'h40, 32'h0, 32'h0, 0, 32'h40, 1);
        step(1, 0, 0, 0, 32'h140, 32'h44, 1, 32'h44, 1);
        // slow memory, branch while fetch outstanding
        step(0, 0, 0, 0, 32'h0, 32'h0, 0, 32'h44, 1);
        step(0, 0, 1, 32'h80, 32'h0, 32'h0, 0, 32'h44, 1);
        step(0, 0, 0, 0, 32'h0, 32'h0, 0, 32'h44, 1);
        step(1, 0, 0, 0, 32'h0, 32'h0, 0, 32'h80, 1);
        step(1, 0, 0, 0, 32'h180, 32'h84, 1, 32'h84, 1);
        // branch plus stall while in HOLD
        step(1, 1, 0, 0, 32'h180, 32'h84, 1, 32'h88, 0);
        step(1, 1, 1, 32'h20, 32'h0, 32'h0, 0, 32'h20, 1);
        step(1, 0, 0, 0, 32'h120, 32'h24, 1, 32'h24, 1);
        // PC wraparound
        step(1, 0, 1, 32'hFFFF_FFFC, 32'h0, 32'h0, 0, 32'hFFFF_FFFC, 1);
        step(1, 0, 0, 0, 32'hFC, 32'h0, 1, 32'h0, 1);
        step(1, 0, 0, 0, 32'h100, 32'h4, 1, 32'h4, 1);
        step(0, 1, 0, 0, 32'h100, 32'h4, 1, 32'h4, 1);

        // async reset while the fetch waits
        #5;
        rst = 1'b1;
        #1;
        chk("arst_instr", instr_ID, 32'h0);
        chk("arst_valid", {31'd0, valid_ID}, 32'h0);
        chk("arst_pc4", pc_incr4_ID, 32'h0);
        chk("arst_pc", pc_IF, 32'h0);
        chk("arst_req", {31'd0, imem_req}, 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        step(1, 0, 0, 0, 32'h100, 32'h4, 1, 32'h4, 1);

        for (int i = 0; i < 10 && q.size() > 0; i++)
            @(posedge clk);
        #6;
        if (q.size() != 0) begin
            bad++;
            total++;
            $display("FAIL drain: %0d left expected 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
